// File: rtl/patrol_enemy.sv
// patrol_enemy: patrolling walker sprite with stomp/side-hit contact sorting and a walk/squish/gone life cycle.
// Define PATROL_ENEMY_RESPAWN_EN to bring the enemy back RESPAWN_FRAMES frames after it disappears.
module patrol_enemy #(
    parameter int W              = 18,
    parameter int X_START        = 1696,
    parameter int Y_POS          = 408,
    parameter int X_MIN          = 1536,
    parameter int X_MAX          = 1836,
    parameter int STEP           = 1,
    parameter int HALF_W         = 16,
    parameter int HIT_RANGE      = 32,
    parameter int STOMP_DY       = 16,
    parameter int SQUISH_FRAMES  = 30,
    parameter int RESPAWN_FRAMES = 120,
    parameter logic [1:0] PLAY_STATE = 2'b01
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [1:0]   game_state,
    input  logic [W-1:0] Ball_X_Pos,
    input  logic [W-1:0] Ball_Y_Pos,
    input  logic [W-1:0] background_offset,
    output logic [W-1:0] enemy_X_Pos_rel,
    output logic [W-1:0] enemy_Y_Pos_rel,
    output logic         is_right,
    output logic         alive,
    output logic         visible,
    output logic         squished,
    output logic         stomp,
    output logic         hit_player
);
    typedef enum logic [1:0] {WALK_L, WALK_R, SQUISHED, GONE} state_t;

    localparam logic [W-1:0] XS    = W'(X_START);
    localparam logic [W-1:0] YP    = W'(Y_POS);
    localparam logic [W-1:0] LIM_L = W'(X_MIN + HALF_W);
    localparam logic [W-1:0] LIM_R = W'(X_MAX - HALF_W);
    localparam logic [W-1:0] XMX   = W'(X_MAX);
    localparam logic [W-1:0] HW    = W'(HALF_W);
    localparam logic [W-1:0] STP   = W'(STEP);
    localparam logic [W-1:0] HR    = W'(HIT_RANGE);
    localparam logic [W-1:0] SDY   = W'(STOMP_DY);
    localparam logic [W-1:0] SQ_N  = W'(SQUISH_FRAMES - 1);
    localparam logic [W-1:0] RS_N  = W'(RESPAWN_FRAMES - 1);

    state_t       state_q, state_d;
    logic [W-1:0] x_q, x_d, cnt_q, cnt_d;
    logic         stomp_q, stomp_d, hit_q, hit_d;
    logic [W-1:0] bx;
    logic         overlap, above, walking;

    assign bx      = Ball_X_Pos + background_offset;
    assign overlap = (bx + HR >= x_q) && (bx <= x_q + HR) &&
                     (Ball_Y_Pos + HR >= YP) && (Ball_Y_Pos <= YP + HR);
    assign above   = Ball_Y_Pos + SDY <= YP;
    assign walking = (state_q == WALK_L) || (state_q == WALK_R);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        stomp_d = 1'b0;
        hit_d   = hit_q;
        if (game_state != PLAY_STATE) begin
            state_d = WALK_L;
            x_d     = XS;
            cnt_d   = '0;
            hit_d   = 1'b0;
        end else if (walking) begin
            if (overlap && above) begin
                state_d = SQUISHED;
                cnt_d   = SQ_N;
                stomp_d = 1'b1;
            end else begin
                hit_d = hit_q | overlap;
                if (state_q == WALK_L) begin
                    state_d = (x_q <= LIM_L + STP) ? WALK_R : WALK_L;
                    x_d     = (x_q <= LIM_L + STP) ? LIM_L : x_q - STP;
                end else begin
                    state_d = (x_q + STP + HW >= XMX) ? WALK_L : WALK_R;
                    x_d     = (x_q + STP + HW >= XMX) ? LIM_R : x_q + STP;
                end
            end
        end else if (state_q == SQUISHED) begin
            // the respawn delay is preloaded on the way into GONE
            state_d = (cnt_q == '0) ? GONE : SQUISHED;
            cnt_d   = (cnt_q == '0) ? RS_N : cnt_q - 1'b1;
        end
`ifdef PATROL_ENEMY_RESPAWN_EN
        else begin
            state_d = (cnt_q == '0) ? WALK_L : GONE;
            x_d     = (cnt_q == '0) ? XS : x_q;
            cnt_d   = cnt_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= WALK_L;
            x_q     <= XS;
            cnt_q   <= '0;
            stomp_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            stomp_q <= stomp_d;
            hit_q   <= hit_d;
        end
    end

    assign enemy_X_Pos_rel = x_q - background_offset;
    assign enemy_Y_Pos_rel = YP;
    assign is_right        = state_q == WALK_R;
    assign alive           = walking;
    assign visible         = state_q != GONE;
    assign squished        = state_q == SQUISHED;
    assign stomp           = stomp_q;
    assign hit_player      = hit_q;
endmodule

// File: tb/tb_patrol_enemy.sv
// tb_patrol_enemy: table-driven frame sequences with a scoreboard queue, plus hand-written reset and turn-stomp corners.
module tb_patrol_enemy;
    localparam int W = 18;
`ifdef PATROL_ENEMY_RESPAWN_EN
    localparam bit RESP = 1'b1;
`else
    localparam bit RESP = 1'b0;
`endif

    logic         frame_clk = 1'b0;
    logic         Reset = 1'b0;
    logic [1:0]   game_state = 2'b01;
    logic [W-1:0] Ball_X_Pos = '0;
    logic [W-1:0] Ball_Y_Pos = 18'd100;
    logic [W-1:0] background_offset = '0;
    logic [W-1:0] enemy_X_Pos_rel, enemy_Y_Pos_rel;
    logic         is_right, alive, visible, squished, stomp, hit_player;
    int           errors = 0;
    int           checks = 0;

    typedef struct {
        logic [1:0]   gs;
        logic [W-1:0] bx, by, off;
        int           n;
        int           x;
        logic         r, a, v, s, st, h;
    } vec_t;

    typedef struct {
        int    x;
        logic  r, a, v, s, st, h;
        string tag;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[18];

    patrol_enemy dut (
        .frame_clk(frame_clk), .Reset(Reset), .game_state(game_state),
        .Ball_X_Pos(Ball_X_Pos), .Ball_Y_Pos(Ball_Y_Pos), .background_offset(background_offset),
        .enemy_X_Pos_rel(enemy_X_Pos_rel), .enemy_Y_Pos_rel(enemy_Y_Pos_rel),
        .is_right(is_right), .alive(alive), .visible(visible), .squished(squished),
        .stomp(stomp), .hit_player(hit_player)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t v(input logic [1:0] gs, input int bx, input int by, input int off, input int n,
                               input int x, input logic r, input logic a, input logic vis,
                               input logic s, input logic st, input logic h);
        vec_t t;
        t.gs = gs; t.bx = W'(bx); t.by = W'(by); t.off = W'(off); t.n = n;
        t.x = x; t.r = r; t.a = a; t.v = vis; t.s = s; t.st = st; t.h = h;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        chk({e.tag, ".x_rel"}, int'(enemy_X_Pos_rel), e.x);
        chk({e.tag, ".y_rel"}, int'(enemy_Y_Pos_rel), 408);
        chk({e.tag, ".is_right"}, int'(is_right), int'(e.r));
        chk({e.tag, ".alive"}, int'(alive), int'(e.a));
        chk({e.tag, ".visible"}, int'(visible), int'(e.v));
        chk({e.tag, ".squished"}, int'(squished), int'(e.s));
        chk({e.tag, ".stomp"}, int'(stomp), int'(e.st));
        chk({e.tag, ".hit_player"}, int'(hit_player), int'(e.h));
    endtask

    task automatic run_row(input vec_t t, input string tag);
        exp_t         e;
        logic [W-1:0] g;
        game_state = t.gs;
        Ball_X_Pos = t.bx;
        Ball_Y_Pos = t.by;
        background_offset = t.off;
        sb.push_back('{x: t.x, r: t.r, a: t.a, v: t.v, s: t.s, st: t.st, h: t.h, tag: tag});
        if (t.n == 0) #1;
        for (int k = 0; k < t.n; k++) begin
            @(posedge frame_clk);
            #1;
            if (alive && game_state == 2'b01) begin
                g = enemy_X_Pos_rel + background_offset;
                chk({tag, ".patrol_range"}, int'(g >= 1552 && g <= 1820), 1);
            end
        end
        e = sb.pop_front();
        compare(e);
    endtask

    initial begin
        tbl[0]  = v(2'b01,   0, 100,    0,   0, 1696, 0, 1, 1, 0, 0, 0);
        tbl[1]  = v(2'b01,   0, 100,    0, 143, 1553, 0, 1, 1, 0, 0, 0);
        tbl[2]  = v(2'b01,   0, 100,    0,   1, 1552, 1, 1, 1, 0, 0, 0);
        tbl[3]  = v(2'b01,   0, 100,    0, 267, 1819, 1, 1, 1, 0, 0, 0);
        tbl[4]  = v(2'b01,   0, 100,    0,   1, 1820, 0, 1, 1, 0, 0, 0);
        tbl[5]  = v(2'b01,   0, 100,    0,   1, 1819, 0, 1, 1, 0, 0, 0);
        tbl[6]  = v(2'b10,   0, 100,    0,   1, 1696, 0, 1, 1, 0, 0, 0);
        tbl[7]  = v(2'b01, 496, 408, 1200,   1,  495, 0, 1, 1, 0, 0, 1);
        tbl[8]  = v(2'b01,   0, 100, 1200,   5,  490, 0, 1, 1, 0, 0, 1);
        tbl[9]  = v(2'b01, 490, 380, 1200,   1,  490, 0, 0, 1, 1, 1, 1);
        tbl[10] = v(2'b01, 490, 380, 1200,   1,  490, 0, 0, 1, 1, 0, 1);
        tbl[11] = v(2'b01, 490, 380, 1200,  28,  490, 0, 0, 1, 1, 0, 1);
        tbl[12] = v(2'b01, 490, 380, 1200,   1,  490, 0, 0, 0, 0, 0, 1);
        tbl[13] = v(2'b01,   0, 100, 1200, 119,  490, 0, 0, 0, 0, 0, 1);
        tbl[14] = v(2'b01,   0, 100, 1200,   1, RESP ? 496 : 490, 0, RESP, RESP, 0, 0, 1);
        tbl[15] = v(2'b01,   0, 100, 1200,  10, RESP ? 486 : 490, 0, RESP, RESP, 0, 0, 1);
        tbl[16] = v(2'b01,   0, 100, 1200, 370, RESP ? 588 : 490, RESP, RESP, RESP, 0, 0, 1);
        tbl[17] = v(2'b00,   0, 100, 1200,   1,  496, 0, 1, 1, 0, 0, 0);

        #12;
        for (int i = 0; i < 18; i++) begin
            run_row(tbl[i], $sformatf("row%0d", i));
            if (i == 0) Reset = 1'b1;
        end

        // async reset in the middle of a squish
        game_state = 2'b01; Ball_X_Pos = 18'd496; Ball_Y_Pos = 18'd380; background_offset = 18'd1200;
        @(posedge frame_clk); #1;
        chk("ar.stomp", int'(stomp), 1);
        chk("ar.squished", int'(squished), 1);
        repeat (5) @(posedge frame_clk);
        #1;
        chk("ar.still_squished", int'(squished), 1);
        chk("ar.stomp_low", int'(stomp), 0);
        #2 Reset = 1'b0;
        #1;
        chk("ar.squished_cleared", int'(squished), 0);
        chk("ar.alive", int'(alive), 1);
        chk("ar.visible", int'(visible), 1);
        chk("ar.x_rel", int'(enemy_X_Pos_rel), 496);
        Ball_X_Pos = '0; Ball_Y_Pos = 18'd100;
        @(negedge frame_clk) Reset = 1'b1;
        @(posedge frame_clk); #1;
        chk("ar.walk_x_rel", int'(enemy_X_Pos_rel), 495);
        chk("ar.walk_alive", int'(alive), 1);

        // stomp on the turn-around frame keeps the pre-turn X
        game_state = 2'b00; background_offset = '0;
        @(posedge frame_clk); #1;
        chk("ts.restart_x", int'(enemy_X_Pos_rel), 1696);
        game_state = 2'b01;
        repeat (143) @(posedge frame_clk);
        #1;
        chk("ts.pre_turn_x", int'(enemy_X_Pos_rel), 1553);
        Ball_X_Pos = 18'd1553; Ball_Y_Pos = 18'd380;
        @(posedge frame_clk); #1;
        chk("ts.stomp", int'(stomp), 1);
        chk("ts.x_frozen", int'(enemy_X_Pos_rel), 1553);
        chk("ts.is_right", int'(is_right), 0);
        chk("ts.hit_player", int'(hit_player), 0);
        chk("ts.squished", int'(squished), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/patrol_enemy.md
Name: patrol_enemy

Overview:
- Parametrised patrolling enemy for the level sprite layer; one instance per walker, with its own patrol window, speed and start point.
- Keeps its own position in level (global) coordinates and outputs its screen-relative position for the sprite renderer.
- Sorts player contact into a stomp from above or a side hit.
- Steps through a walk / squish / gone life cycle, updated once per frame.

Parameters:
- W, 18: width of all position/offset buses.
- X_START, 1696: global X centre at reset or (re)start.
- Y_POS, 408: fixed Y centre.
- X_MIN, 1536: global left patrol limit; the enemy's left edge never goes below it.
- X_MAX, 1836: global right patrol limit; the enemy's right edge never goes above it.
- STEP, 1: pixels moved per frame.
- HALF_W, 16: half sprite width.
- HIT_RANGE, 32: contact window half-size, X and Y.
- STOMP_DY, 16: ball must be at least this far above Y_POS for a contact to count as a stomp.
- SQUISH_FRAMES, 30: frames the squished sprite stays visible.
- RESPAWN_FRAMES, 120: frames spent in GONE before respawn (optional feature only).
- PLAY_STATE, 2'b01: game_state value in which the enemy runs.

Ports:
- frame_clk  in  1  frame-rate clock; the only clock.
- Reset  in  1  asynchronous, active-low reset.
- game_state  in  2  top-level game FSM state.
- Ball_X_Pos  in  W  player screen X.
- Ball_Y_Pos  in  W  player Y.
- background_offset  in  W  scroll offset (global = screen + offset).
- enemy_X_Pos_rel  out  W  enemy X minus background_offset, combinational from the X register.
- enemy_Y_Pos_rel  out  W  enemy Y.
- is_right  out  1  1 while walking right.
- alive  out  1  1 in WALK_L/WALK_R.
- visible  out  1  1 in WALK_L/WALK_R/SQUISHED.
- squished  out  1  1 in SQUISHED (sprite select).
- stomp  out  1  single-frame pulse on stomp.
- hit_player  out  1  sticky side-hit flag.

Behaviour:
- Reset values, applied while Reset=0 and also synchronously on any frame where game_state != PLAY_STATE:
  - state WALK_L; X=X_START; counter=0.
  - is_right=0, alive=1, visible=1, squished=0, stomp=0, hit_player=0.
- Arithmetic and contact test:
  - All arithmetic is unsigned W-bit. Comparisons are written as sums so nothing underflows.
  - Ball global X: BX = Ball_X_Pos + background_offset.
  - overlap = (BX + HIT_RANGE >= X) && (BX <= X + HIT_RANGE) && (Ball_Y_Pos + HIT_RANGE >= Y_POS) && (Ball_Y_Pos <= Y_POS + HIT_RANGE).
  - above = (Ball_Y_Pos + STOMP_DY <= Y_POS).
- State transitions, evaluated once per frame_clk edge:
  - WALK_L:
    - overlap && above: stomp<=1, go to SQUISHED, counter<=SQUISH_FRAMES-1; X frozen.
    - overlap && !above: hit_player<=1; movement continues.
    - Movement: if X - STEP <= X_MIN + HALF_W, then X <= X_MIN + HALF_W and go to WALK_R (is_right<=1). Otherwise X <= X - STEP.
  - WALK_R: mirror of WALK_L. If X + STEP + HALF_W >= X_MAX, then X <= X_MAX - HALF_W and go to WALK_L.
  - SQUISHED: no contact evaluation. Counter decrements each frame; at 0, go to GONE.
  - GONE: alive=0, visible=0, no contact, no motion. Terminal unless the optional feature is enabled.
- stomp is high for exactly the one frame after entry to SQUISHED; it is 0 every other frame.
- Simultaneous events:
  - Stomp has priority over side hit; a stomp frame never sets hit_player.
  - A stomp on the same frame as a turn-around freezes X at its pre-turn value.
- hit_player stays set until reset or until game_state leaves PLAY_STATE.
- Reset mid-squish or mid-respawn aborts the counter and restarts the enemy in WALK_L at X_START.
- Latency: every output except enemy_X_Pos_rel is registered and updates one frame after the inputs that cause it.

Optional Feature:
- Macro: PATROL_ENEMY_RESPAWN_EN.
- Defined:
  - Entering GONE loads counter<=RESPAWN_FRAMES-1.
  - At 0, go to WALK_L with X=X_START and alive=visible=1.
  - hit_player is not cleared on respawn.
- Undefined: GONE is terminal until reset or game_state change; RESPAWN_FRAMES is unused.

Test Plan:
- Patrol, left turn: Reset pulse low, game_state=01, ball far away (Ball_X_Pos=0, offset=0, Ball_Y_Pos=100) -> X=1553 after 143 frames; frame 144 gives X=1552 with is_right=1.
- Patrol, right turn: continue the same run -> X reaches 1820, then is_right=0; X never exceeds 1820 and never goes below 1552.
- Stomp: offset=1200, Ball_X_Pos=496 (BX=1696), Ball_Y_Pos=380 while WALK_L at X=1696 -> stomp high one frame, squished=1, alive=0; after 30 frames visible=0.
- Side hit: same X setup with Ball_Y_Pos=408 -> hit_player=1 (sticky) and stomp=0. Movement continues. Moving the ball away leaves hit_player=1; game_state=00 for one frame clears it.
- Game state and async reset: game_state=10 mid-walk -> next frame X=1696, WALK_L. Reset asserted low between clock edges mid-squish -> outputs return to reset values immediately.
- Respawn (macro defined): after GONE, 120 frames -> alive=1, X=1696, is_right=0. With the macro undefined, alive stays 0 for 500 frames.
